// File: rtl/display_pkg.sv
// Shared definitions for the two-digit 7-segment scan driver.
//   state_e     : scan FSM state encoding (display and gap states)
//   AN_*        : active-low anode patterns, An[0] = ones, An[1] = tens
package display_pkg;

   typedef enum logic [1:0] {
      StOnes = 2'd0,
      StGap1 = 2'd1,
      StTens = 2'd2,
      StGap0 = 2'd3
   } state_e;

   localparam logic [1:0] AN_OFF  = 2'b11;
   localparam logic [1:0] AN_ONES = 2'b10;
   localparam logic [1:0] AN_TENS = 2'b01;

endpackage

// File: rtl/digit_scan_ctrl_if.sv
// Load/Ready handshake carrying a BCD pair into the scan driver.
//   load  : request to capture tens/ones (accepted only while ready=1)
//   tens  : BCD tens value
//   ones  : BCD ones value
//   ready : 1 = no load pending
// master drives the request side, slave is the scan driver.
interface digit_scan_ctrl_if;

   logic       load;
   logic [3:0] tens;
   logic [3:0] ones;
   logic       ready;

   modport master (
      output load,
      output tens,
      output ones,
      input  ready
   );

   modport slave (
      input  load,
      input  tens,
      input  ones,
      output ready
   );

endinterface

// File: rtl/scan_timer.sv
// Cycle counter with synchronous clear and terminal-count compare.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset (counter to 0)
//   clr_i   : synchronous clear, takes priority over counting
//   limit_i : terminal count value compared against the current count
//   tc_o    : 1 while the count equals limit_i
module scan_timer #(
   parameter int unsigned CNT_W = 17
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic [CNT_W-1:0] limit_i,
   output logic             tc_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = clr_i ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == limit_i);

endmodule

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexing driver for a two-digit 7-segment display.
//   clk_i       : clock
//   rst_i       : synchronous active-high reset
//   enable_i    : 1 = scanning, 0 = display dark (parked in GAP0)
//   blank_lz_i  : 1 = keep tens dark when the held tens digit is 0
//   ld_if       : Load/Ready handshake for the displayed BCD pair
//   held_tens_o : committed tens digit (mux I1)
//   held_ones_o : committed ones digit (mux I0)
//   s0_o        : digit select, 0 = ones, 1 = tens
//   an_o        : active-low anodes, [0] = ones, [1] = tens
// New digits are committed only in gap states, so a lit digit never changes.
module digit_scan_ctrl
   import display_pkg::*;
#(
   parameter int unsigned REFRESH_CYCLES = 100000,
   parameter int unsigned GAP_CYCLES     = 64,
   parameter int unsigned CNT_W          = 17
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     enable_i,
   input  logic                     blank_lz_i,
   digit_scan_ctrl_if.slave         ld_if,
   output logic [3:0]               held_tens_o,
   output logic [3:0]               held_ones_o,
   output logic                     s0_o,
   output logic [1:0]               an_o
);

   localparam logic [CNT_W-1:0] RefLim = CNT_W'(REFRESH_CYCLES - 1);
   localparam logic [CNT_W-1:0] GapLim = CNT_W'(GAP_CYCLES - 1);

   state_e           state_q, state_d;
   logic             s0_q, s0_d;
   logic [1:0]       an_q, an_d;
   logic             pending_q, pending_d;
   logic [3:0]       pend_tens_q, pend_tens_d;
   logic [3:0]       pend_ones_q, pend_ones_d;
   logic [3:0]       held_tens_q, held_tens_d;
   logic [3:0]       held_ones_q, held_ones_d;
   logic [CNT_W-1:0] limit;
   logic             tc;
   logic             cnt_clr;
   logic             in_gap;

   always_comb begin
      limit = ((state_q == StOnes) || (state_q == StTens)) ? RefLim : GapLim;
   end

   // Counter restarts on every state change and is held at 0 while disabled.
   assign cnt_clr = !enable_i || (state_d != state_q);

   scan_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (cnt_clr),
      .limit_i (limit),
      .tc_o    (tc)
   );

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      if (!enable_i) begin
         state_d = StGap0;
      end else begin
         unique case (state_q)
            StOnes: if (tc) state_d = StGap1;
            StGap1: if (tc) state_d = StTens;
            StTens: if (tc) state_d = StGap0;
            StGap0: if (tc) state_d = StOnes;
            default: state_d = StGap0;
         endcase
      end
   end

   // Handshake and shadow registers; commits only happen in gap states.
   assign in_gap = (state_q == StGap0) || (state_q == StGap1);

   always_comb begin
      pending_d   = pending_q;
      pend_tens_d = pend_tens_q;
      pend_ones_d = pend_ones_q;
      held_tens_d = held_tens_q;
      held_ones_d = held_ones_q;
      if (ld_if.load && !pending_q) begin
         pending_d   = 1'b1;
         pend_tens_d = ld_if.tens;
         pend_ones_d = ld_if.ones;
      end else if (pending_q && in_gap) begin
         pending_d   = 1'b0;
         held_tens_d = pend_tens_q;
         held_ones_d = pend_ones_q;
      end
   end

   // Outputs are registered alongside the state, so decode from state_d.
   // held_tens_d covers a commit on the same edge that enters TENS.
   always_comb begin
      s0_d = (state_d == StGap1) || (state_d == StTens);
      an_d = AN_OFF;
      unique case (state_d)
         StOnes:  an_d = AN_ONES;
         StTens:  an_d = (blank_lz_i && (held_tens_d == 4'd0)) ? AN_OFF : AN_TENS;
         default: an_d = AN_OFF;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StGap0;
         s0_q        <= 1'b0;
         an_q        <= AN_OFF;
         pending_q   <= 1'b0;
         pend_tens_q <= 4'd0;
         pend_ones_q <= 4'd0;
         held_tens_q <= 4'd0;
         held_ones_q <= 4'd0;
      end else begin
         state_q     <= state_d;
         s0_q        <= s0_d;
         an_q        <= an_d;
         pending_q   <= pending_d;
         pend_tens_q <= pend_tens_d;
         pend_ones_q <= pend_ones_d;
         held_tens_q <= held_tens_d;
         held_ones_q <= held_ones_d;
      end
   end

   assign ld_if.ready = !pending_q;
   assign held_tens_o = held_tens_q;
   assign held_ones_o = held_ones_q;
   assign s0_o        = s0_q;
   assign an_o        = an_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl with REFRESH_CYCLES=4, GAP_CYCLES=2.
// k counts cycles from the reset edge; the scan pattern repeats every 12.
module tb_digit_scan_ctrl;

   logic       clk;
   logic       rst;
   logic       enable;
   logic       blank_lz;
   logic [3:0] held_tens;
   logic [3:0] held_ones;
   logic       s0;
   logic [1:0] an;

   int n_checks = 0;
   int n_pass   = 0;
   int k        = 0;

   digit_scan_ctrl_if bus ();

   digit_scan_ctrl #(
      .REFRESH_CYCLES (4),
      .GAP_CYCLES     (2),
      .CNT_W          (17)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .enable_i    (enable),
      .blank_lz_i  (blank_lz),
      .ld_if       (bus),
      .held_tens_o (held_tens),
      .held_ones_o (held_ones),
      .s0_o        (s0),
      .an_o        (an)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h (k=%0d)", tag, got, exp, k);
      end
   endtask

   // Advance one clock; observe on the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
      k++;
   endtask

   function automatic logic [1:0] exp_an(input int kk);
      int p;
      p = kk % 12;
      if (p < 2)       return 2'b11;
      else if (p < 6)  return 2'b10;
      else if (p < 8)  return 2'b11;
      else             return 2'b01;
   endfunction

   function automatic logic exp_s0(input int kk);
      int p;
      p = kk % 12;
      return (p >= 6);
   endfunction

   initial begin
      rst       = 1'b1;
      enable    = 1'b1;
      blank_lz  = 1'b0;
      bus.load  = 1'b0;
      bus.tens  = 4'd0;
      bus.ones  = 4'd0;

      // 1. Reset and free-running scan pattern.
      @(negedge clk);
      step();
      rst = 1'b0;
      k   = 0;
      check_eq("rst_an", 32'(an), 32'h3);
      check_eq("rst_s0", 32'(s0), 32'h0);
      check_eq("rst_ready", 32'(bus.ready), 32'h1);
      check_eq("rst_held", 32'({held_tens, held_ones}), 32'h00);
      for (int i = 1; i < 24; i++) begin
         step();
         check_eq("scan_an", 32'(an), 32'(exp_an(k)));
         check_eq("scan_s0", 32'(s0), 32'(exp_s0(k)));
      end

      // 2/3. Load 4/7 in ONES, second load ignored, commit in GAP1.
      while (k < 26) step();
      check_eq("ones_an", 32'(an), 32'h2);
      bus.load = 1'b1; bus.tens = 4'd4; bus.ones = 4'd7;
      step();                                   // k=27
      check_eq("ready_low", 32'(bus.ready), 32'h0);
      bus.tens = 4'd9; bus.ones = 4'd9;         // ignored while busy
      step();                                   // k=28
      bus.load = 1'b0;
      check_eq("ready_still_low", 32'(bus.ready), 32'h0);
      check_eq("held_before", 32'({held_tens, held_ones}), 32'h00);
      step(); step();                           // k=30 first GAP1 cycle
      check_eq("gap1_an", 32'(an), 32'h3);
      check_eq("gap1_held_old", 32'({held_tens, held_ones}), 32'h00);
      step();                                   // k=31 after commit edge
      check_eq("commit_held", 32'({held_tens, held_ones}), 32'h47);
      check_eq("commit_ready", 32'(bus.ready), 32'h1);
      step();                                   // k=32 TENS
      check_eq("tens_an", 32'(an), 32'h1);
      check_eq("tens_s0", 32'(s0), 32'h1);
      step(); step(); step();                   // k=35
      check_eq("held_stable", 32'({held_tens, held_ones}), 32'h47);

      // 4. Leading-zero blanking.
      blank_lz = 1'b1;
      bus.load = 1'b1; bus.tens = 4'd0; bus.ones = 4'd5;
      step();                                   // k=36 GAP0, pending
      bus.load = 1'b0;
      step();                                   // k=37 committed
      check_eq("lz_held", 32'({held_tens, held_ones}), 32'h05);
      step();                                   // k=38 ONES
      check_eq("lz_ones_an", 32'(an), 32'h2);
      while (k < 44) step();
      for (int i = 0; i < 4; i++) begin
         check_eq("lz_tens_an", 32'(an), 32'h3);
         if (i == 0) check_eq("lz_tens_s0", 32'(s0), 32'h1);
         step();
      end                                       // k=48 GAP0
      bus.load = 1'b1; bus.tens = 4'd1; bus.ones = 4'd2;
      step();                                   // k=49
      bus.load = 1'b0;
      step();                                   // k=50 committed
      check_eq("lz1_held", 32'({held_tens, held_ones}), 32'h12);
      while (k < 56) step();
      check_eq("lz1_tens_an", 32'(an), 32'h1);

      // 5. Disable during TENS, load while dark, re-enable.
      enable = 1'b0;
      step();
      check_eq("dis_an", 32'(an), 32'h3);
      check_eq("dis_s0", 32'(s0), 32'h0);
      bus.load = 1'b1; bus.tens = 4'd3; bus.ones = 4'd8;
      step();
      bus.load = 1'b0;
      check_eq("dis_ready", 32'(bus.ready), 32'h0);
      step();
      check_eq("dis_commit", 32'({held_tens, held_ones}), 32'h38);
      check_eq("dis_ready_back", 32'(bus.ready), 32'h1);
      for (int i = 0; i < 5; i++) begin
         step();
         check_eq("dis_hold_an", 32'(an), 32'h3);
      end
      enable = 1'b1;
      step();
      check_eq("reen_an1", 32'(an), 32'h3);
      step();
      check_eq("reen_an2", 32'(an), 32'h2);
      k = 2;                                    // resync to first ONES cycle

      // 6. Reset with a load pending mid-TENS.
      while (k < 8) step();
      check_eq("pre_rst_an", 32'(an), 32'h1);
      bus.load = 1'b1; bus.tens = 4'd6; bus.ones = 4'd6;
      step();                                   // k=9, pending
      bus.load = 1'b0;
      check_eq("pre_rst_ready", 32'(bus.ready), 32'h0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_eq("mid_rst_ready", 32'(bus.ready), 32'h1);
      check_eq("mid_rst_held", 32'({held_tens, held_ones}), 32'h00);
      check_eq("mid_rst_an", 32'(an), 32'h3);
      check_eq("mid_rst_s0", 32'(s0), 32'h0);
      for (int i = 0; i < 16; i++) step();
      check_eq("no_stale_commit", 32'({held_tens, held_ones}), 32'h00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
